// File: rtl/cmp_share_arbiter_if.sv
// cmp_share_arbiter_if: request/operand/result bundle between two comparator
// clients (master side) and the shared comparator arbiter (slave side).
interface cmp_share_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             a_big;
  logic             b_big;
  logic             equal;
  logic             busy;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, done0, done1, a_big, b_big, equal, busy
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, done0, done1, a_big, b_big, equal, busy
  );
endinterface

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: shares one registered unsigned magnitude comparator
// between two requesters. IDLE picks a requester and latches its operands,
// CMP pulses the grant and compares, RESP pulses done with one-hot flags.
// Optional macro CMP_ARB_FIXED_PRIO_EN: requester 0 always wins a tie
// (default build is round-robin via the ptr register).
module cmp_share_arbiter #(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  cmp_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             owner;
  logic             owner_nx;
  logic             ptr;
  logic             ptr_nx;
  logic             load;
  logic             sel;

  logic [WIDTH-1:0] op_a_p0;
  logic [WIDTH-1:0] op_b_p0;

  logic             gnt0_r;
  logic             gnt1_r;
  logic             done0_r;
  logic             done1_r;
  logic             busy_r;
  logic [2:0]       flags_r;

  logic             gnt0_nx;
  logic             gnt1_nx;
  logic             done0_nx;
  logic             done1_nx;
  logic             busy_nx;
  logic [2:0]       flags_nx;

  // Arbitration choice: returns the index (0/1) of the winning requester.
  function automatic logic pick(input logic r0, input logic r1, input logic p);
`ifdef CMP_ARB_FIXED_PRIO_EN
    pick = !r0;
`else
    if (r0 && r1) begin
      pick = p;
    end else begin
      pick = r1;
    end
`endif
  endfunction

  // Unsigned magnitude compare, packed as {a_big, b_big, equal}.
  function automatic logic [2:0] compare(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
    if (a > b) begin
      compare = 3'b100;
    end else if (a < b) begin
      compare = 3'b010;
    end else begin
      compare = 3'b001;
    end
  endfunction

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx   = ptr;
    load     = 1'b0;
    sel      = 1'b0;
    gnt0_nx  = 1'b0;
    gnt1_nx  = 1'b0;
    done0_nx = 1'b0;
    done1_nx = 1'b0;
    busy_nx  = 1'b0;
    flags_nx = flags_r;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          sel      = pick(bus.req0, bus.req1, ptr);
          load     = 1'b1;
          owner_nx = sel;
          gnt0_nx  = !sel;
          gnt1_nx  = sel;
          busy_nx  = 1'b1;
          state_nx = CMP;
        end
      end
      CMP: begin
        flags_nx = compare(op_a_p0, op_b_p0);
        done0_nx = !owner;
        done1_nx = owner;
        busy_nx  = 1'b1;
        state_nx = RESP;
      end
      RESP: begin
        ptr_nx   = !owner;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      ptr     <= 1'b0;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      busy_r  <= 1'b0;
      flags_r <= 3'b000;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      ptr     <= ptr_nx;
      gnt0_r  <= gnt0_nx;
      gnt1_r  <= gnt1_nx;
      done0_r <= done0_nx;
      done1_r <= done1_nx;
      busy_r  <= busy_nx;
      flags_r <= flags_nx;
    end
  end

  // Stage p0: operand capture at the IDLE sampling edge; later operand
  // changes on the bus do not reach the comparison in flight.
  always_ff @(posedge clk) begin
    if (load) begin
      op_a_p0 <= sel ? bus.a1 : bus.a0;
      op_b_p0 <= sel ? bus.b1 : bus.b0;
    end
  end

  assign bus.gnt0  = gnt0_r;
  assign bus.gnt1  = gnt1_r;
  assign bus.done0 = done0_r;
  assign bus.done1 = done1_r;
  assign bus.busy  = busy_r;
  assign bus.a_big = flags_r[2];
  assign bus.b_big = flags_r[1];
  assign bus.equal = flags_r[0];

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb_cmp_share_arbiter: directed and randomized bench for cmp_share_arbiter.
// Reference model schedules grant/done events per sampling edge from the
// arbitration rules (latency 2, one operation per 3 cycles).
module tb_cmp_share_arbiter;
  localparam int WIDTH = 4;
  localparam int MAXC  = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cmp_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

  cmp_share_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         cyc;
  int         next_free;
  int         ptr_m;
  int         sch_gnt  [MAXC];
  int         sch_done [MAXC];
  logic [2:0] sch_flags[MAXC];
  logic       m_gnt0, m_gnt1, m_done0, m_done1, m_busy;
  logic [2:0] m_flags;
  bit         drop0, drop1;

  function automatic logic [2:0] ref_flags(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int choose(input logic r0, input logic r1);
`ifdef CMP_ARB_FIXED_PRIO_EN
    return r0 ? 0 : 1;
`else
    if (r0 && r1) return ptr_m;
    return r0 ? 0 : 1;
`endif
  endfunction

  // One clock: update the model from the inputs this edge samples, advance,
  // derive expectations, then let auto-dropping requesters react to grants.
  task automatic tick();
    int who;
    bit rst_was;
    rst_was = !rst_n;
    if (!rst_n) begin
      for (int k = cyc; k < MAXC; k++) begin
        sch_gnt[k]  = -1;
        sch_done[k] = -1;
      end
      ptr_m     = 0;
      next_free = cyc + 1;
    end else if (cyc >= next_free && (bus.req0 || bus.req1)) begin
      who                = choose(bus.req0, bus.req1);
      sch_gnt[cyc]       = who;
      sch_done[cyc + 1]  = who;
      sch_flags[cyc + 1] = (who == 0) ? ref_flags(bus.a0, bus.b0) : ref_flags(bus.a1, bus.b1);
      next_free          = cyc + 3;
      ptr_m              = 1 - who;
    end
    @(posedge clk);
    #1;
    m_gnt0  = (sch_gnt[cyc] == 0);
    m_gnt1  = (sch_gnt[cyc] == 1);
    m_done0 = (sch_done[cyc] == 0);
    m_done1 = (sch_done[cyc] == 1);
    m_busy  = (sch_gnt[cyc] != -1) || (sch_done[cyc] != -1);
    if (rst_was) m_flags = 3'b000;
    else if (sch_done[cyc] != -1) m_flags = sch_flags[cyc];
    if (m_gnt0 && drop0) begin
      bus.req0 = 1'b0;
      bus.a0   = 4'($urandom);
      bus.b0   = 4'($urandom);
    end
    if (m_gnt1 && drop1) begin
      bus.req1 = 1'b0;
      bus.a1   = 4'($urandom);
      bus.b1   = 4'($urandom);
    end
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    tick();
    tick();
    n_checks++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 00000", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy});
    end
    n_checks++;
    if ({bus.a_big, bus.b_big, bus.equal} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000", {bus.a_big, bus.b_big, bus.equal});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int gnt_at = -1;
    int done_at = -1;
    drop0 = 1; drop1 = 1;
    bus.a0 = 4'd9; bus.b0 = 4'd3; bus.req0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== {m_gnt0, m_gnt1, m_done0, m_done1, m_busy}) begin
        n_fail++;
        $display("FAIL single_ctl cyc %0d: got %b want %b", i,
                 {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}, {m_gnt0, m_gnt1, m_done0, m_done1, m_busy});
      end
      if (bus.gnt0 === 1'b1 && gnt_at < 0) gnt_at = i;
      if (bus.done0 === 1'b1) begin
        done_at = i;
        n_checks++;
        if ({bus.a_big, bus.b_big, bus.equal} !== 3'b100) begin
          n_fail++;
          $display("FAIL single_flags: got %b want 100", {bus.a_big, bus.b_big, bus.equal});
        end
      end
    end
    n_checks++;
    if (gnt_at != 0 || done_at != 1) begin
      n_fail++;
      $display("FAIL single_latency: gnt at %0d done at %0d want 0 and 1", gnt_at, done_at);
    end
  endtask

  task automatic test_req1_seq();
    logic [3:0] a_t[2];
    logic [3:0] b_t[2];
    logic [2:0] f_t[2];
    a_t[0] = 4'd5; b_t[0] = 4'd5;  f_t[0] = 3'b001;
    a_t[1] = 4'd2; b_t[1] = 4'd14; f_t[1] = 3'b010;
    drop0 = 1; drop1 = 1;
    for (int t = 0; t < 2; t++) begin
      int dones = 0;
      bus.a1 = a_t[t]; bus.b1 = b_t[t]; bus.req1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
        tick();
        n_checks++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== {m_gnt0, m_gnt1, m_done0, m_done1, m_busy}) begin
          n_fail++;
          $display("FAIL req1_ctl t%0d cyc %0d: got %b want %b", t, i,
                   {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}, {m_gnt0, m_gnt1, m_done0, m_done1, m_busy});
        end
        if (bus.done1 === 1'b1) dones++;
        if (dones > 0) begin
          n_checks++;
          if ({bus.a_big, bus.b_big, bus.equal} !== f_t[t]) begin
            n_fail++;
            $display("FAIL req1_flags t%0d cyc %0d: got %b want %b", t, i, {bus.a_big, bus.b_big, bus.equal}, f_t[t]);
          end
        end
      end
      n_checks++;
      if (dones != 1) begin
        n_fail++;
        $display("FAIL req1_done_count t%0d: got %0d want 1", t, dones);
      end
    end
  endtask

`ifndef CMP_ARB_FIXED_PRIO_EN
  task automatic test_round_robin();
    int order[$];
    int first;
    first = ptr_m;
    drop0 = 0; drop1 = 0;
    bus.a0 = 4'd15; bus.b0 = 4'd0; bus.a1 = 4'd0; bus.b1 = 4'd15;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 12) begin
        bus.req0 = 1'b0; bus.req1 = 1'b0;
      end
      tick();
      n_checks++;
      if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== {m_gnt0, m_gnt1, m_done0, m_done1, m_busy}) begin
        n_fail++;
        $display("FAIL rr_ctl cyc %0d: got %b want %b", i,
                 {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}, {m_gnt0, m_gnt1, m_done0, m_done1, m_busy});
      end
      if (bus.gnt0 === 1'b1) order.push_back(0);
      if (bus.gnt1 === 1'b1) order.push_back(1);
      if (bus.done0 === 1'b1 || bus.done1 === 1'b1) begin
        n_checks++;
        if ({bus.a_big, bus.b_big, bus.equal} !== (bus.done0 ? 3'b100 : 3'b010)) begin
          n_fail++;
          $display("FAIL rr_flags cyc %0d: got %b want %b", i, {bus.a_big, bus.b_big, bus.equal}, bus.done0 ? 3'b100 : 3'b010);
        end
      end
    end
    n_checks++;
    if (order.size() != 4) begin
      n_fail++;
      $display("FAIL rr_grant_count: got %0d want 4", order.size());
    end
    for (int k = 0; k < order.size(); k++) begin
      n_checks++;
      if (order[k] != ((first + k) % 2)) begin
        n_fail++;
        $display("FAIL rr_order idx %0d: got %0d want %0d", k, order[k], (first + k) % 2);
      end
    end
  endtask
`else
  task automatic test_fixed_prio();
    int g1 = 0;
    int after = -1;
    drop0 = 0; drop1 = 1;
    bus.a0 = 4'd3; bus.b0 = 4'd8; bus.a1 = 4'd8; bus.b1 = 4'd3;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== {m_gnt0, m_gnt1, m_done0, m_done1, m_busy}) begin
        n_fail++;
        $display("FAIL fixed_ctl cyc %0d: got %b want %b", i,
                 {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}, {m_gnt0, m_gnt1, m_done0, m_done1, m_busy});
      end
      if (bus.gnt1 === 1'b1) g1++;
    end
    n_checks++;
    if (g1 != 0) begin
      n_fail++;
      $display("FAIL fixed_no_gnt1: got %0d grants want 0", g1);
    end
    bus.req0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.gnt1 === 1'b1 && after < 0) after = i + 1;
    end
    n_checks++;
    if (after < 1 || after > 3) begin
      n_fail++;
      $display("FAIL fixed_gnt1_after_drop: got %0d want 1..3", after);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int g0 = 0;
    drop0 = 1; drop1 = 1;
    bus.a0 = 4'd7; bus.b0 = 4'd2; bus.req0 = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.a_big, bus.b_big, bus.equal} !== 8'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b want 00000000",
               {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.a_big, bus.b_big, bus.equal});
    end
    bus.a0 = 4'd1; bus.b0 = 4'd1; bus.a1 = 4'd4; bus.b1 = 4'd9;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== {m_gnt0, m_gnt1, m_done0, m_done1, m_busy}) begin
        n_fail++;
        $display("FAIL rstmid_ctl cyc %0d: got %b want %b", i,
                 {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}, {m_gnt0, m_gnt1, m_done0, m_done1, m_busy});
      end
      if (i == 0) g0 = bus.gnt0;
    end
    n_checks++;
    if (g0 != 1) begin
      n_fail++;
      $display("FAIL rstmid_first_grant: gnt0 got %0d want 1", g0);
    end
  endtask

  task automatic test_boundary();
    logic [3:0] a_t[4];
    logic [3:0] b_t[4];
    logic [2:0] f_t[4];
    a_t[0] = 4'd0;  b_t[0] = 4'd0;  f_t[0] = 3'b001;
    a_t[1] = 4'd15; b_t[1] = 4'd15; f_t[1] = 3'b001;
    a_t[2] = 4'd0;  b_t[2] = 4'd15; f_t[2] = 3'b010;
    a_t[3] = 4'd15; b_t[3] = 4'd0;  f_t[3] = 3'b100;
    drop0 = 1; drop1 = 1;
    bus.req1 = 1'b0;
    for (int t = 0; t < 4; t++) begin
      bit seen = 0;
      bus.a0 = a_t[t]; bus.b0 = b_t[t]; bus.req0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (bus.done0 === 1'b1) begin
          seen = 1;
          n_checks++;
          if ({bus.a_big, bus.b_big, bus.equal} !== f_t[t]) begin
            n_fail++;
            $display("FAIL boundary %0d/%0d: got %b want %b", a_t[t], b_t[t], {bus.a_big, bus.b_big, bus.equal}, f_t[t]);
          end
        end
      end
      n_checks++;
      if (!seen) begin
        n_fail++;
        $display("FAIL boundary_done %0d/%0d: got no done0 want one", a_t[t], b_t[t]);
      end
    end
  endtask

  task automatic test_random();
    drop0 = 1; drop1 = 1;
    for (int i = 0; i < 600; i++) begin
      if (!bus.req0 && $urandom_range(2) == 0) begin
        bus.a0 = 4'($urandom); bus.b0 = 4'($urandom); bus.req0 = 1'b1;
      end
      if (!bus.req1 && $urandom_range(2) == 0) begin
        bus.a1 = 4'($urandom); bus.b1 = 4'($urandom); bus.req1 = 1'b1;
      end
      tick();
      n_checks++;
      if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== {m_gnt0, m_gnt1, m_done0, m_done1, m_busy}) begin
        n_fail++;
        $display("FAIL random_ctl cyc %0d: got %b want %b", i,
                 {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}, {m_gnt0, m_gnt1, m_done0, m_done1, m_busy});
      end
      n_checks++;
      if ({bus.a_big, bus.b_big, bus.equal} !== m_flags) begin
        n_fail++;
        $display("FAIL random_flags cyc %0d: got %b want %b", i, {bus.a_big, bus.b_big, bus.equal}, m_flags);
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    for (int k = 0; k < MAXC; k++) begin
      sch_gnt[k]   = -1;
      sch_done[k]  = -1;
      sch_flags[k] = 3'b000;
    end
    cyc = 0; next_free = 0; ptr_m = 0; m_flags = 3'b000;
    drop0 = 1; drop1 = 1;
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    test_reset();
    test_single();
    test_req1_seq();
`ifndef CMP_ARB_FIXED_PRIO_EN
    test_round_robin();
`else
    test_fixed_prio();
`endif
    test_reset_mid();
    test_boundary();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
